idiv64_seq: RTL and testbench
=============================

Name: idiv64_seq

Overview:
- Multi-cycle 64-bit integer divider controller for the integer ALU; handles RISC-V DIV/DIVU/REM/REMU and the W variants.
- Registers operands, normalises signs, and iterates the combinational radix-16 stage `divstage64` once per cycle (4 quotient bits per cycle).
- Applies sign and special-case correction, then returns a registered result with a one-cycle valid pulse to the execute stage.

Parameters:
- STAGE_BITS, 4, quotient bits produced per iteration. Only 4 is supported, matching the `divstage64` contract.

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous active-low reset
- i_ena  in  1  start request. Sampled only in IDLE.
- i_unsigned  in  1  1 = DIVU/REMU, 0 = signed
- i_rv32  in  1  1 = W-variant: operands use bits [31:0], result is sign-extended from bit 31
- i_residual  in  1  1 = return remainder, 0 = return quotient
- i_a1  in  64  dividend
- i_a2  in  64  divisor
- o_res  out  64  result. Held stable until the next o_valid.
- o_valid  out  1  one-cycle result strobe
- o_busy  out  1  high when state != IDLE

Behaviour:
- Reset: asynchronous, active-low. All registers clear: state=IDLE, o_res=0, o_valid=0, o_busy=0. Reset mid-operation aborts silently; no o_valid is produced.
- States:
  - IDLE -> CALC on the i_ena edge.
  - CALC runs N_ITER cycles: 16 for 64-bit, 8 for rv32.
  - CALC -> FIX after the last iteration.
  - FIX -> IDLE. o_valid=1 and o_res are registered in the cycle after FIX.
- Latency: i_ena sampled at edge 0 gives o_valid high in cycle 18 (64-bit) or cycle 10 (rv32). Latency is constant for all operands, including special cases.
- Back-to-back: i_ena may be accepted in the same cycle o_valid is high, because state is already IDLE. i_ena while busy is ignored and not queued.
- Operand capture in the accept cycle:
  - rv32: sign-extend (signed) or zero-extend (unsigned) bits [31:0].
  - Signed mode: sa = a1[63], sb = a2[63]; store |a1| and |a2| as 64-bit unsigned. |0x8000_0000_0000_0000| = 2^63 fits.
  - rv32 dividend is pre-shifted left by 32 so that 8 iterations consume its 32 significant bits.
  - Flag zdiv = (divisor == 0).
- Iteration (`divstage64` contract):
  - r' = (r << 4) | next 4 dividend bits (MSB first).
  - q = floor(r'/d), with 0 <= q <= 15; r <- r' - q*d.
  - Remainder register is 68 bits; quotient is shifted in 4 bits per cycle.
- FIX:
  - Quotient is negated iff signed and (sa ^ sb) and !zdiv.
  - Remainder is negated iff signed and sa.
  - rv32 result = sign-extend(result[31:0]).
- Special cases (RISC-V):
  - Divide by zero: quotient = all ones; remainder = original dividend. The raw long division already yields this; only the quotient negation is suppressed.
  - Signed overflow MIN/-1: quotient = MIN, remainder = 0. This falls out of the datapath; no extra logic.
- o_valid is exactly one cycle wide. o_res holds its value afterwards.

Decomposition:
- `divstage64_pkg`: holds the shared constants.
  - N_ITER64 = 16, N_ITER32 = 8, STAGE_BITS = 4.
  - State enum idiv_state_t {IDLE, CALC, FIX}.
  - The 68-bit remainder width constant.
- Sub-module: `divstage64` only, instantiated once and combinational, fed from registered remainder, divisor and dividend nibble.
- Sign/abs and final negation stay inline.

Test Plan:
- Unsigned 64-bit, a1=100, a2=7: residual=0 gives o_res=14 at cycle 18; residual=1 gives o_res=2. o_busy high cycles 1-17.
- Signed, a1=-7, a2=2: quotient=0xFFFF_FFFF_FFFF_FFFD (-3); remainder=0xFFFF_FFFF_FFFF_FFFF (-1).
- Divide by zero, signed, a1=-5, a2=0: quotient=0xFFFF_FFFF_FFFF_FFFF; remainder=0xFFFF_FFFF_FFFF_FFFB. Latency is still 18.
- Overflow:
  - 64-bit signed, a1=0x8000_0000_0000_0000, a2=-1: quotient=0x8000_0000_0000_0000, remainder=0.
  - rv32 signed, a1=0x8000_0000, a2=0xFFFF_FFFF: quotient=0xFFFF_FFFF_8000_0000 at cycle 10.
- Handshake:
  - i_ena pulses during CALC are ignored, giving exactly one o_valid.
  - i_ena in the o_valid cycle starts a second op whose o_valid lands 18 cycles later.
- Reset: i_nrst low at cycle 5 of an op clears o_busy/o_res/o_valid asynchronously. No o_valid afterwards. The next op works normally.

Source files
------------

// File: rtl/divstage64_pkg.sv
// Shared constants and state encoding for the sequential 64-bit divider.
package divstage64_pkg;

  localparam int N_ITER64   = 16;
  localparam int N_ITER32   = 8;
  localparam int STAGE_BITS = 4;
  localparam int REM_W      = 68;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } idiv_state_t;

endpackage

// File: rtl/divstage64.sv
// Combinational radix-16 restoring division step: shifts in one dividend nibble
// and extracts 4 quotient bits. A zero divisor yields q=15 with the remainder untouched.
module divstage64
  import divstage64_pkg::*;
(
  input  logic [REM_W-1:0]      rem_in,
  input  logic [63:0]           divisor,
  input  logic [STAGE_BITS-1:0] nib,
  output logic [STAGE_BITS-1:0] q,
  output logic [REM_W-1:0]      rem_out
);

  logic [REM_W-1:0] acc;
  logic [REM_W-1:0] dsh;

  always_comb begin
    acc = (rem_in << STAGE_BITS) | {{(REM_W-STAGE_BITS){1'b0}}, nib};
    dsh = '0;
    q   = '0;
    for (int k = STAGE_BITS - 1; k >= 0; k--) begin
      dsh = {{(REM_W-64){1'b0}}, divisor} << k;
      if (acc >= dsh) begin
        acc  = acc - dsh;
        q[k] = 1'b1;
      end
    end
    rem_out = acc;
  end

endmodule

// File: rtl/idiv64_seq.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU (+W) divider, 4 quotient bits per cycle.
// Result strobes 18 cycles (10 for rv32) after the accepting edge; requests while busy are dropped.
module idiv64_seq #(
  parameter int STAGE_BITS = 4
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_ena,
  input  logic        i_unsigned,
  input  logic        i_rv32,
  input  logic        i_residual,
  input  logic [63:0] i_a1,
  input  logic [63:0] i_a2,
  output logic [63:0] o_res,
  output logic        o_valid,
  output logic        o_busy
);
  import divstage64_pkg::*;

  idiv_state_t      state;
  logic [3:0]       cnt;
  logic [63:0]      dvd;
  logic [63:0]      dvs;
  logic [REM_W-1:0] rem;
  logic [63:0]      quo;
  logic             f_uns, f_rv32, f_res, f_sa, f_sb, f_zdiv;

  logic [63:0] a_ext, b_ext, a_abs, b_abs;
  logic        sa, sb;

  always_comb begin
    a_ext = i_a1;
    b_ext = i_a2;
    if (i_rv32) begin
      a_ext = i_unsigned ? {32'b0, i_a1[31:0]} : {{32{i_a1[31]}}, i_a1[31:0]};
      b_ext = i_unsigned ? {32'b0, i_a2[31:0]} : {{32{i_a2[31]}}, i_a2[31:0]};
    end
    sa    = !i_unsigned && a_ext[63];
    sb    = !i_unsigned && b_ext[63];
    // Negating MIN wraps back to 2^63, which is its correct unsigned magnitude.
    a_abs = sa ? -a_ext : a_ext;
    b_abs = sb ? -b_ext : b_ext;
  end

  logic [STAGE_BITS-1:0] stage_q;
  logic [REM_W-1:0]      stage_rem;

  divstage64 u_stage (
    .rem_in  (rem),
    .divisor (dvs),
    .nib     (dvd[63 -: STAGE_BITS]),
    .q       (stage_q),
    .rem_out (stage_rem)
  );

  logic [63:0] q_fix, r_fix, sel, res_fin;

  always_comb begin
    q_fix   = (!f_uns && (f_sa ^ f_sb) && !f_zdiv) ? -quo : quo;
    r_fix   = (!f_uns && f_sa) ? -rem[63:0] : rem[63:0];
    sel     = f_res ? r_fix : q_fix;
    res_fin = f_rv32 ? {{32{sel[31]}}, sel[31:0]} : sel;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      quo     <= '0;
      f_uns   <= 1'b0;
      f_rv32  <= 1'b0;
      f_res   <= 1'b0;
      f_sa    <= 1'b0;
      f_sb    <= 1'b0;
      f_zdiv  <= 1'b0;
      o_res   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_ena) begin
            state  <= CALC;
            cnt    <= i_rv32 ? 4'(N_ITER32 - 1) : 4'(N_ITER64 - 1);
            // Left-align the 32 significant rv32 bits so 8 nibbles consume them.
            dvd    <= i_rv32 ? {a_abs[31:0], 32'b0} : a_abs;
            dvs    <= b_abs;
            rem    <= '0;
            quo    <= '0;
            f_uns  <= i_unsigned;
            f_rv32 <= i_rv32;
            f_res  <= i_residual;
            f_sa   <= sa;
            f_sb   <= sb;
            f_zdiv <= (b_ext == 64'd0);
          end
        end
        CALC: begin
          dvd <= dvd << STAGE_BITS;
          rem <= stage_rem;
          quo <= {quo[63-STAGE_BITS:0], stage_q};
          if (cnt == 4'd0) state <= FIX;
          else             cnt   <= cnt - 4'd1;
        end
        FIX: begin
          state   <= IDLE;
          o_res   <= res_fin;
          o_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_idiv64_seq.sv
// Randomized and directed bench for idiv64_seq with an arithmetic reference model and cycle scoreboard.
module tb_idiv64_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_ena = 1'b0;
  logic        i_unsigned = 1'b0;
  logic        i_rv32 = 1'b0;
  logic        i_residual = 1'b0;
  logic [63:0] i_a1 = '0;
  logic [63:0] i_a2 = '0;
  logic [63:0] o_res;
  logic        o_valid;
  logic        o_busy;

  idiv64_seq #(.STAGE_BITS(4)) dut (
    .i_clk      (clk),
    .i_nrst     (rst_n),
    .i_ena      (i_ena),
    .i_unsigned (i_unsigned),
    .i_rv32     (i_rv32),
    .i_residual (i_residual),
    .i_a1       (i_a1),
    .i_a2       (i_a2),
    .o_res      (o_res),
    .o_valid    (o_valid),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V division semantics, straight from the ISA rules.
  function automatic logic [63:0] ref_div(logic u, logic w, logic r,
                                          logic [63:0] a1, logic [63:0] a2);
    logic [31:0] ua32, ub32, q32, r32;
    int          sa32, sb32;
    logic [63:0] q64, r64;
    longint      sa64, sb64;
    if (w) begin
      ua32 = a1[31:0];
      ub32 = a2[31:0];
      if (u) begin
        if (ub32 == 0) begin q32 = '1; r32 = ua32; end
        else begin q32 = ua32 / ub32; r32 = ua32 % ub32; end
      end else begin
        sa32 = int'(ua32);
        sb32 = int'(ub32);
        if (sb32 == 0) begin q32 = '1; r32 = ua32; end
        else if (ua32 == 32'h8000_0000 && sb32 == -1) begin q32 = ua32; r32 = 0; end
        else begin q32 = 32'(sa32 / sb32); r32 = 32'(sa32 % sb32); end
      end
      return r ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    if (u) begin
      if (a2 == 0) begin q64 = '1; r64 = a1; end
      else begin q64 = a1 / a2; r64 = a1 % a2; end
    end else begin
      sa64 = longint'(a1);
      sb64 = longint'(a2);
      if (sb64 == 0) begin q64 = '1; r64 = a1; end
      else if (a1 == 64'h8000_0000_0000_0000 && sb64 == -1) begin q64 = a1; r64 = 0; end
      else begin q64 = 64'(sa64 / sb64); r64 = 64'(sa64 % sb64); end
    end
    return r ? r64 : q64;
  endfunction

  typedef struct {
    int          due;
    logic [63:0] val;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          next_free = 0;
  logic [63:0] last_res = '0;
  int          n_valid = 0;

  // Acceptance model: a request is taken when the unit is idle; result appears a fixed time later.
  always @(posedge clk) begin
    int   lat;
    exp_t e;
    if (rst_n && i_ena && cyc >= next_free) begin
      lat   = i_rv32 ? 10 : 18;
      e.due = cyc + lat;
      e.val = ref_div(i_unsigned, i_rv32, i_residual, i_a1, i_a2);
      sbq.push_back(e);
      next_free = cyc + lat;
    end
    cyc++;
  end

  initial begin
    logic exp_v;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        sbq.delete();
        last_res  = '0;
        next_free = cyc;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_res", o_res, 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
      end else begin
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
          check("sb_missed", 64'(sbq[0].due), 64'(cyc));
          void'(sbq.pop_front());
        end
        exp_v = (sbq.size() > 0 && sbq[0].due == cyc);
        check("sb_valid", 64'(o_valid), 64'(exp_v));
        if (exp_v) begin
          last_res = sbq[0].val;
          void'(sbq.pop_front());
        end
        if (o_valid) n_valid++;
        check("sb_res", o_res, last_res);
        check("sb_busy", 64'(o_busy), 64'(cyc < next_free));
      end
    end
  end

  task automatic run_op(string name, logic u, logic w, logic r,
                        logic [63:0] a, logic [63:0] b, logic [63:0] exp, int lat);
    int n;
    i_unsigned = u; i_rv32 = w; i_residual = r; i_a1 = a; i_a2 = b;
    i_ena = 1'b1;
    @(negedge clk);
    i_ena = 1'b0;
    n = 1;
    while (!o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_lat"}, 64'(n), 64'(lat));
    check(name, o_res, exp);
  endtask

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'h8000_0000_0000_0000;
      2: return '1;
      3: return 64'($urandom_range(0, 20));
      4: return {32'($urandom), 32'h8000_0000};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    int nv0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("m_divu", ref_div(1, 0, 0, 100, 7), 64'd14);
    check("m_remu", ref_div(1, 0, 1, 100, 7), 64'd2);
    check("m_div_neg", ref_div(0, 0, 0, -64'sd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("m_rem_neg", ref_div(0, 0, 1, -64'sd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    check("m_div0", ref_div(0, 0, 0, -64'sd5, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    check("m_rem0", ref_div(0, 0, 1, -64'sd5, 64'd0), 64'hFFFF_FFFF_FFFF_FFFB);
    check("m_ovf32", ref_div(0, 1, 0, 64'h8000_0000, 64'hFFFF_FFFF), 64'hFFFF_FFFF_8000_0000);

    run_op("divu", 1, 0, 0, 64'd100, 64'd7, 64'd14, 18);
    run_op("remu_b2b", 1, 0, 1, 64'd100, 64'd7, 64'd2, 18);
    run_op("div_neg", 0, 0, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 18);
    run_op("rem_neg", 0, 0, 1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 18);
    run_op("div_zero", 0, 0, 0, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 18);
    run_op("rem_zero", 0, 0, 1, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 18);
    run_op("div_ovf", 0, 0, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 18);
    run_op("rem_ovf", 0, 0, 1, 64'h8000_0000_0000_0000, '1, 64'd0, 18);
    run_op("divw_ovf", 0, 1, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 10);
    run_op("remuw", 1, 1, 1, 64'hDEAD_0000_0000_0011, 64'd5, 64'd2, 10);

    // Requests while busy must be dropped, not queued.
    repeat (2) @(negedge clk);
    nv0 = n_valid;
    i_unsigned = 1; i_rv32 = 0; i_residual = 0; i_a1 = 64'd1000; i_a2 = 64'd10;
    i_ena = 1'b1;
    @(negedge clk);
    i_ena = 1'b0;
    repeat (3) @(negedge clk);
    i_a1 = 64'd77; i_ena = 1'b1;
    repeat (2) @(negedge clk);
    i_ena = 1'b0;
    repeat (40) @(negedge clk);
    check("busy_ignore_cnt", 64'(n_valid - nv0), 64'd1);
    check("busy_ignore_res", o_res, 64'd100);

    // Reset mid-operation aborts without a result.
    i_a1 = 64'd12345; i_a2 = 64'd3; i_ena = 1'b1;
    @(negedge clk);
    i_ena = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(o_busy), 64'd0);
    check("arst_res", o_res, 64'd0);
    check("arst_valid", 64'(o_valid), 64'd0);
    nv0 = n_valid;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("arst_no_valid", 64'(n_valid - nv0), 64'd0);
    run_op("after_rst", 1, 0, 0, 64'd12345, 64'd3, 64'd4115, 18);

    nv0 = n_valid;
    for (int i = 0; i < 4000; i++) begin
      i_ena      = ($urandom_range(0, 3) == 0);
      i_unsigned = 1'($urandom_range(0, 1));
      i_rv32     = 1'($urandom_range(0, 1));
      i_residual = 1'($urandom_range(0, 1));
      i_a1       = rnd_opnd();
      i_a2       = rnd_opnd();
      @(negedge clk);
    end
    i_ena = 1'b0;
    repeat (25) @(negedge clk);
    check("rand_results", 64'(n_valid - nv0 >= 150), 64'd1);
    check("rand_drained", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
